// File: rtl/rand_pkg.sv
// Shared definitions for the card dealer: LFSR tap table, reset seed,
// FSM state encoding and card width.
package rand_pkg;

   // Each card is one nibble of the cards bus.
   localparam int CARD_W = 4;

   // Maximal-length feedback masks, indexed by LFSR width 4..16.
   // Bit n-1 set means stage n feeds the XOR that becomes the new LSB.
   localparam logic [15:0] TAPS [4:16] = '{
      16'h000C,  // 4 : x^4+x^3+1
      16'h0014,  // 5 : x^5+x^3+1
      16'h0030,  // 6 : x^6+x^5+1
      16'h0060,  // 7 : x^7+x^6+1
      16'h00B8,  // 8 : x^8+x^6+x^5+x^4+1
      16'h0110,  // 9 : x^9+x^5+1
      16'h0240,  // 10: x^10+x^7+1
      16'h0500,  // 11: x^11+x^9+1
      16'h0829,  // 12: x^12+x^6+x^4+x+1
      16'h100D,  // 13: x^13+x^4+x^3+x+1
      16'h2015,  // 14: x^14+x^5+x^3+x+1
      16'h6000,  // 15: x^15+x^14+1
      16'hD008   // 16: x^16+x^15+x^13+x^4+1
   };

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DRAW = 2'd1,
      DONE = 2'd2
   } deal_state_t;

   // Reset / zero-replacement seed: the 1010... pattern kept to 'width' LSBs.
   function automatic logic [15:0] default_seed(int width);
      logic [15:0] pat;
      logic [15:0] mask;
      pat  = 16'hAAAA;
      mask = 16'((32'd1 << width) - 32'd1);
      return pat & mask;
   endfunction

endpackage

// File: rtl/rand_deal_if.sv
// Control/status bundle between a deal requester and rand_deal.
interface rand_deal_if
   import rand_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int NUM_CARDS = 4
);

   // Handshake: start is a level request sampled only while the dealer is
   // idle (busy = 0); while busy it is ignored and never queued. done is a
   // one-cycle pulse marking the end of a deal; card_valid then stays high
   // with cards stable until the next accepted start or reset. seed_load is
   // an unconditional command taking effect on the edge it is sampled.
   logic                          seed_load;
   logic [WIDTH-1:0]              seed;
   logic                          start;
   logic                          busy;
   logic                          done;
   logic                          card_valid;
   logic [CARD_W*NUM_CARDS-1:0]   cards;
   logic [WIDTH-1:0]              lfsr_q;
   deal_state_t                   state_dbg;

   modport master (
      output seed_load, seed, start,
      input  busy, done, card_valid, cards, lfsr_q, state_dbg
   );

   modport slave (
      input  seed_load, seed, start,
      output busy, done, card_valid, cards, lfsr_q, state_dbg
   );

endinterface

// File: rtl/rand_deal_lfsr_core.sv
// Free-running Fibonacci LFSR (shift left, XOR feedback into the LSB) with
// a synchronous load port; a zero load value is replaced by the default seed
// so the lock-up state is never entered.
module lfsr_core #(
   parameter int          WIDTH = 8,
   parameter logic [15:0] TAPS  = rand_pkg::TAPS[WIDTH]
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] q
);

   localparam logic [15:0]      SEED_FULL = rand_pkg::default_seed(WIDTH);
   localparam logic [WIDTH-1:0] SEED      = SEED_FULL[WIDTH-1:0];
   localparam logic [WIDTH-1:0] TAP_MASK  = TAPS[WIDTH-1:0];

   logic             fb;
   logic [WIDTH-1:0] q_next;

   // Next state: load wins over the shift; zero is never allowed through.
   always_comb begin
      fb     = ^(q & TAP_MASK);
      q_next = {q[WIDTH-2:0], fb};
      if (load) begin
         q_next = (din == '0) ? SEED : din;
      end
      if (q_next == '0) begin
         q_next = SEED;
      end
   end

   // State register, reset to the default seed.
   always_ff @(posedge clk) begin
      if (rst) begin
         q <= SEED;
      end else begin
         q <= q_next;
      end
   end

endmodule

// File: rtl/rand_deal.sv
// Card dealer: draws NUM_CARDS values in 1..MAX_VAL from the low nibble of a
// free-running LFSR, rejecting out-of-range samples.
// Optional feature macro: RAND_DEAL_NODUP_EN -- also rejects a sample equal
// to a card already accepted in the current deal.
module rand_deal
   import rand_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int NUM_CARDS = 4,
   parameter int MAX_VAL   = 13
) (
   input  logic        clk,
   input  logic        rst,
   rand_deal_if.slave  bus
);

   localparam int                 IDX_W    = $clog2(NUM_CARDS + 1);
   localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_CARDS - 1);
   localparam logic [CARD_W-1:0]  MAX_V    = CARD_W'(MAX_VAL);
   localparam int                 CARDS_W  = CARD_W * NUM_CARDS;

   deal_state_t        state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [CARDS_W-1:0] cards_q, cards_d;
   logic               valid_q, valid_d;

   logic [WIDTH-1:0]   lfsr_q;
   logic [CARD_W-1:0]  sample;
   logic               in_range;
   logic               dup;
   logic               accept;

   lfsr_core #(
      .WIDTH (WIDTH),
      .TAPS  (TAPS[WIDTH])
   ) u_lfsr (
      .clk  (clk),
      .rst  (rst),
      .load (bus.seed_load),
      .din  (bus.seed),
      .q    (lfsr_q)
   );

   assign sample   = lfsr_q[CARD_W-1:0];
   assign in_range = (sample != '0) && (sample <= MAX_V);

`ifdef RAND_DEAL_NODUP_EN
   // A deal without duplicates needs at least as many values as cards.
   if (MAX_VAL < NUM_CARDS) begin : g_bad_cfg
      $error("rand_deal: MAX_VAL must be >= NUM_CARDS when duplicates are rejected");
   end

   // Flag a sample that matches any card already accepted in this deal.
   always_comb begin
      dup = 1'b0;
      for (int k = 0; k < NUM_CARDS; k++) begin
         if ((IDX_W'(k) < idx_q) && (cards_q[k*CARD_W +: CARD_W] == sample)) begin
            dup = 1'b1;
         end
      end
   end
`else
   assign dup = 1'b0;
`endif

   assign accept = (state_q == DRAW) && in_range && !dup;

   // Next-state and card-store update.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cards_d = cards_q;
      valid_d = valid_q;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d = DRAW;
               idx_d   = '0;
               cards_d = '0;
               valid_d = 1'b0;
            end
         end
         DRAW: begin
            if (accept) begin
               for (int k = 0; k < NUM_CARDS; k++) begin
                  if (IDX_W'(k) == idx_q) begin
                     cards_d[k*CARD_W +: CARD_W] = sample;
                  end
               end
               idx_d = idx_q + IDX_W'(1);
               if (idx_q == LAST_IDX) begin
                  state_d = DONE;
                  valid_d = 1'b1;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Registers; reset aborts any deal in flight without a done pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         cards_q <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cards_q <= cards_d;
         valid_q <= valid_d;
      end
   end

   assign bus.busy       = (state_q != IDLE);
   assign bus.done       = (state_q == DONE);
   assign bus.card_valid = valid_q;
   assign bus.cards      = cards_q;
   assign bus.lfsr_q     = lfsr_q;
   assign bus.state_dbg  = state_q;

endmodule
